// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants: opcodes, immediate kind coding (same as ImmSrc
// on the decode side) and the legal immediate ranges.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_I   = 2'b00,
    IMM_S   = 2'b01,
    IMM_B   = 2'b10,
    IMM_BAD = 2'b11
  } imm_kind_e;

  localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_IS_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX  = 32'sd4094;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input channel and encoded-word output channel of instr_encoder.
// slave is the encoder side, master the producer/consumer side.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational fields-to-word packer for lw/sw/beq, plus a flag raised when the
// immediate does not fit its field (or a branch offset is odd).
module imm_pack
  import riscv_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        range_viol_o
);

  // Pack per immediate format and flag out-of-range immediates
  always_comb begin
    instr_o      = 32'h0000_0000;
    range_viol_o = 1'b0;
    case (imm_kind_e'(kind_i))
      IMM_I: begin
        instr_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
        range_viol_o = ($signed(imm_i) < IMM_IS_MIN) || ($signed(imm_i) > IMM_IS_MAX);
      end
      IMM_S: begin
        instr_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
        range_viol_o = ($signed(imm_i) < IMM_IS_MIN) || ($signed(imm_i) > IMM_IS_MAX);
      end
      IMM_B: begin
        // imm[0] has no field: branch targets are halfword aligned
        instr_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], OP_BRANCH};
        range_viol_o = ($signed(imm_i) < IMM_B_MIN) || ($signed(imm_i) > IMM_B_MAX) ||
                       imm_i[0];
      end
      default: begin
        instr_o      = 32'h0000_0000;
        range_viol_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming lw/sw/beq encoder with a one-deep output register and byte-address counter.
// Optional macro IMM_RANGE_CHECK_EN: reject out-of-range/odd immediates and report err.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  instr_encoder_if.slave        bus,
  output logic [15:0]           word_count,
  output logic                  err
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  logic [31:0]       packed_s;
  logic              range_viol_s;
  logic              accept_s;
  logic              out_hs_s;
  logic              reject_s;
  logic              emit_s;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;

  imm_pack u_pack (
    .kind_i       (bus.in_kind),
    .rd_i         (bus.in_rd),
    .rs1_i        (bus.in_rs1),
    .rs2_i        (bus.in_rs2),
    .funct3_i     (bus.in_funct3),
    .imm_i        (bus.in_imm),
    .instr_o      (packed_s),
    .range_viol_o (range_viol_s)
  );

  assign bus.in_ready  = !clear && (!out_valid_q || bus.out_ready);
  assign accept_s      = bus.in_valid && bus.in_ready;
  assign out_hs_s      = out_valid_q && bus.out_ready && !clear;
  assign emit_s        = accept_s && !reject_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = addr_q;
  assign word_count    = count_q;

`ifdef IMM_RANGE_CHECK_EN
  logic err_q, err_d;

  assign reject_s = accept_s && ((bus.in_kind == IMM_BAD) || range_viol_s);
  assign err      = err_q;

  // Sticky error flag next state
  always_comb begin
    if (clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q || reject_s;
    end
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic unused_range_viol_s;

  // Illegal kind is still dropped, silently
  assign reject_s            = accept_s && (bus.in_kind == IMM_BAD);
  assign unused_range_viol_s = range_viol_s;
  assign err                 = 1'b0;
`endif

  // Output register, address and word counter next state; clear wins over handshakes
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    if (clear) begin
      out_valid_d = 1'b0;
      addr_d      = BASE_A;
      count_d     = 16'h0000;
    end else begin
      if (out_hs_s) begin
        addr_d = addr_q + ADDR_W'(4);
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'h0001;
        end else begin
          count_d = count_q;
        end
      end else begin
        addr_d  = addr_q;
        count_d = count_q;
      end
      // A rejected bundle leaves any held word untouched
      if (emit_s) begin
        out_valid_d = 1'b1;
        out_instr_d = packed_s;
      end else if (out_hs_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      addr_q      <= BASE_A;
      count_q     <= 16'h0000;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; expected words are hand-encoded,
// round-trip checks use an independent decode-side immediate extender.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        clear4 = 1'b0;
  logic [15:0] word_count, word_count4;
  logic        err, err4;
  int          total = 0;
  int          bad = 0;

  instr_encoder_if #(.ADDR_W(10)) bus ();
  instr_encoder_if #(.ADDR_W(4))  bus4 ();

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus), .word_count(word_count), .err(err)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear4), .bus(bus4), .word_count(word_count4), .err(err4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [1:0] k, input logic [31:0] w);
    case (k)
      2'b00:   ext = {{20{w[31]}}, w[31:20]};
      2'b01:   ext = {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   ext = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: ext = 32'h0000_0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    bus.in_kind = k; bus.in_rd = rd; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_imm = imm;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; clear4 = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    drive(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    bus4.in_kind = 2'b00; bus4.in_rd = 5'd1; bus4.in_rs1 = 5'd2;
    bus4.in_rs2 = 5'd0; bus4.in_funct3 = 3'd2; bus4.in_imm = 32'd4;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", bus.out_instr); end
    total++; if (bus.out_addr !== 10'h000) begin bad++; $display("FAIL rst_addr got=%h exp=000", bus.out_addr); end
    total++; if (word_count !== 16'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", word_count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_lw();
    do_reset();
    drive(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, -32'sd4);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_instr !== 32'hFFC12283) begin bad++; $display("FAIL lw_instr got=%h exp=FFC12283", bus.out_instr); end
    total++; if (bus.out_addr !== 10'h000) begin bad++; $display("FAIL lw_addr got=%h exp=000", bus.out_addr); end
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lw_drain got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_addr !== 10'h004) begin bad++; $display("FAIL lw_addr2 got=%h exp=004", bus.out_addr); end
    total++; if (word_count !== 16'd1) begin bad++; $display("FAIL lw_count got=%0d exp=1", word_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    drive(2'b01, 5'd0, 5'd2, 5'd6, 3'b010, 32'd8);
    bus.in_valid = 1'b1;
    step();
    drive(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, -32'sd8);
    #1;
    total++; if (bus.out_instr !== 32'h00612423) begin bad++; $display("FAIL b2b_sw got=%h exp=00612423", bus.out_instr); end
    total++; if (bus.out_addr !== 10'h000) begin bad++; $display("FAIL b2b_sw_addr got=%h exp=000", bus.out_addr); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_bubble got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_instr !== 32'hFE208CE3) begin bad++; $display("FAIL b2b_beq got=%h exp=FE208CE3", bus.out_instr); end
    total++; if (bus.out_addr !== 10'h004) begin bad++; $display("FAIL b2b_beq_addr got=%h exp=004", bus.out_addr); end
    step();
    total++; if (word_count !== 16'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", word_count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, -32'sd4);
    bus.in_valid = 1'b1;
    step();
    drive(2'b01, 5'd0, 5'd2, 5'd6, 3'b010, 32'd8);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      total++; if (bus.out_instr !== 32'hFFC12283) begin bad++; $display("FAIL bp_stable cyc=%0d got=%h exp=FFC12283", i, bus.out_instr); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_instr !== 32'h00612423) begin bad++; $display("FAIL bp_second got=%h exp=00612423", bus.out_instr); end
    total++; if (bus.out_addr !== 10'h004) begin bad++; $display("FAIL bp_addr got=%h exp=004", bus.out_addr); end
    step();
    total++; if (word_count !== 16'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", word_count); end
  endtask

  task automatic test_boundary();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    drive(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd2048);
    step();
    total++; if (bus.out_instr !== 32'h80000003) begin bad++; $display("FAIL bnd_i_min got=%h exp=80000003", bus.out_instr); end
    drive(2'b10, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4094);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_instr !== 32'h7E000FE3) begin bad++; $display("FAIL bnd_b_max got=%h exp=7E000FE3", bus.out_instr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bnd_err got=%b exp=0", err); end
    step();
  endtask

  task automatic test_reject();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    drive(2'b00, 5'd1, 5'd0, 5'd0, 3'b010, 32'd2048);
    step();
    drive(2'b10, 5'd0, 5'd0, 5'd0, 3'b000, 32'd3);
`ifdef IMM_RANGE_CHECK_EN
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rej_i_valid got=%b exp=0", bus.out_valid); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_i_err got=%b exp=1", err); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rej_b_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_addr !== 10'h000) begin bad++; $display("FAIL rej_addr got=%h exp=000", bus.out_addr); end
    total++; if (word_count !== 16'd0) begin bad++; $display("FAIL rej_count got=%0d exp=0", word_count); end
`else
    total++; if (bus.out_instr !== 32'h80002083) begin bad++; $display("FAIL trunc_i got=%h exp=80002083", bus.out_instr); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_instr !== 32'h00000163) begin bad++; $display("FAIL trunc_b got=%h exp=00000163", bus.out_instr); end
    total++; if (bus.out_addr !== 10'h004) begin bad++; $display("FAIL trunc_addr got=%h exp=004", bus.out_addr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL trunc_err got=%b exp=0", err); end
`endif
    step();
    // Illegal kind is always dropped
    bus.in_valid = 1'b1;
    drive(2'b11, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL kind11_valid got=%b exp=0", bus.out_valid); end
`ifdef IMM_RANGE_CHECK_EN
    total++; if (err !== 1'b1) begin bad++; $display("FAIL kind11_err got=%b exp=1", err); end
`else
    total++; if (err !== 1'b0) begin bad++; $display("FAIL kind11_err got=%b exp=0", err); end
`endif
  endtask

  task automatic test_wrap();
    logic [3:0] exp_a;
    do_reset();
    bus4.out_ready = 1'b1;
    bus4.in_valid = 1'b1;
    exp_a = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (bus4.out_addr !== exp_a || bus4.out_valid !== 1'b1) begin bad++; $display("FAIL wrap_addr i=%0d got=%h/%b exp=%h/1", i, bus4.out_addr, bus4.out_valid, exp_a); end
      exp_a = exp_a + 4'h4;
    end
    bus4.in_valid = 1'b0;
    step();
    total++; if (word_count4 !== 16'd5) begin bad++; $display("FAIL wrap_count got=%0d exp=5", word_count4); end
  endtask

  task automatic test_clear();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    drive(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    step();
`endif
    drive(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, -32'sd4);
    step();
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    step();
    total++; if (bus.out_addr !== 10'h004) begin bad++; $display("FAIL clr_pre_addr got=%h exp=004", bus.out_addr); end
    drive(2'b01, 5'd0, 5'd2, 5'd6, 3'b010, 32'd8);
    bus.out_ready = 1'b1;
    clear = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b exp=0", bus.in_ready); end
    step();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_addr !== 10'h000) begin bad++; $display("FAIL clr_addr got=%h exp=000", bus.out_addr); end
    total++; if (word_count !== 16'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", word_count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", err); end
  endtask

  task automatic test_roundtrip();
    logic [1:0]  k;
    logic [4:0]  r1;
    logic [31:0] imm;
    int          v;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      k  = 2'(i % 3);
      r1 = 5'($urandom_range(0, 31));
      v  = int'($urandom_range(0, 4095)) - 2048;
      if (k == 2'b10) begin
        v = v * 2;
      end else begin
        v = v;
      end
      imm = 32'(v);
      drive(k, 5'($urandom_range(0, 31)), r1, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), imm);
      bus.in_valid = 1'b1;
      step();
      total++; if (ext(k, bus.out_instr) !== imm) begin bad++; $display("FAIL rt_imm i=%0d got=%h exp=%h", i, ext(k, bus.out_instr), imm); end
      total++; if (bus.out_instr[19:15] !== r1) begin bad++; $display("FAIL rt_rs1 i=%0d got=%0d exp=%0d", i, bus.out_instr[19:15], r1); end
    end
    bus.in_valid = 1'b0;
    step();
    total++; if (word_count !== 16'd24) begin bad++; $display("FAIL rt_count got=%0d exp=24", word_count); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_backpressure();
    test_boundary();
    test_reject();
    test_wrap();
    test_clear();
    test_roundtrip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
